// File: rtl/quad_enc_pkg.sv
// Shared types and constants for the quadrature encoder generator.
// Holds the FSM state type, the phase-to-(A,B) Gray table and the direction codes.
package quad_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // Indexed by phase: 0=00, 1=10, 2=11, 3=01 as {A,B}
    localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic dir);
        return (dir == DIR_REV) ? ph - 2'd1 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/quad_tick_div.sv
// Loadable down-counter that emits a one-cycle tick every load_val enabled cycles.
// Reloads itself from the last loaded value on each tick.
module quad_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] reload;
    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == DIV_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
            cnt    <= '0;
        end else if (load) begin
            reload <= load_val;
            cnt    <= load_val;
        end else if (en) begin
            if (cnt == DIV_W'(1))
                cnt <= reload;
            else
                cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: emits a signed number of A/B quarter-steps
// at a programmable period, tracking a running signed position.
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position
);

    state_t           state;
    state_t           state_nxt;
    logic             dir;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       phase;
    logic [1:0]       phase_nxt;
    logic [CNT_W-1:0] magnitude;
    logic [DIV_W-1:0] period_eff;
    logic             accept;
    logic             tick;
    logic             step;

    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    // Unsigned negation maps the most negative value onto 2^(CNT_W-1)
    assign magnitude  = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
    assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
    // Abort wins over a tick landing in the same cycle
    assign step       = tick && !abort;
    assign phase_nxt  = phase_step(phase, dir);

    quad_tick_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (period_eff),
        .en       (state == RUN),
        .tick     (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (magnitude == '0) ? FIN : RUN;
            RUN: begin
                if (abort)
                    state_nxt = FIN;
                else if (tick && (remaining == CNT_W'(1)))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= DIR_FWD;
            remaining <= '0;
            phase     <= '0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            position  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state == FIN);
            if (accept) begin
                dir       <= cmd_steps[CNT_W-1];
                remaining <= magnitude;
            end
            if (step) begin
                phase          <= phase_nxt;
                {enc_a, enc_b} <= PHASE_AB[phase_nxt];
                position       <= (dir == DIR_REV) ? position - CNT_W'(1) : position + CNT_W'(1);
                remaining      <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/quad_enc_gen.md
Name: quad_enc_gen

Overview:
Quadrature encoder signal generator. It is the transmit side of the encoder interface: it emits A/B quadrature phases for a commanded signed number of quarter-steps at a programmable rate. It is used to emulate motor encoders feeding the user-project encoder inputs (enc0..enc2 on mprj_io[8..13]), and can run on-chip for loopback self-test. One instance per encoder channel.

Parameters:
- CNT_W, 16, width of step command and position counter (signed, two's complement)
- DIV_W, 16, width of quarter-step period (clock cycles)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_steps  in  CNT_W  signed quarter-step count; sign gives direction
- cmd_period  in  DIV_W  clock cycles per quarter-step; 0 treated as 1
- abort  in  1  synchronous stop of current run
- enc_a  out  1  quadrature phase A, registered
- enc_b  out  1  quadrature phase B, registered
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when a run completes or is aborted
- position  out  CNT_W  signed running edge count, registered

Behaviour:
- Reset values: enc_a=0, enc_b=0, busy=0, done=0, position=0, cmd_ready=1 (combinational from state=IDLE), phase=0, state=IDLE.
- States: IDLE, RUN, FIN.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - latch direction = cmd_steps[CNT_W-1];
  - latch magnitude = |cmd_steps| as an unsigned CNT_W value (-2^(CNT_W-1) gives 2^(CNT_W-1));
  - latch period = max(cmd_period,1);
  - load divider with period.
  - If magnitude==0 -> FIN, else -> RUN.
- RUN: busy=1. Divider counts down each cycle; on reaching terminal count (the cycle after period cycles have elapsed since load/reload):
  - advance phase by one (+1 forward, -1 reverse, mod 4);
  - update enc_a/enc_b in that same register update;
  - position += 1 (forward) or -= 1 (reverse), modulo 2^CNT_W (wraps, no saturation);
  - decrement remaining count and reload divider.
  - When remaining reaches 0 -> FIN.
- Phase encoding (A,B): 0=00, 1=10, 2=11, 3=01. Forward makes A lead B. Exactly one output changes per quarter-step (Gray).
- Latency: first edge appears exactly period cycles after the accept cycle. Subsequent edges are spaced exactly period cycles apart.
- FIN: done=1 for exactly one cycle, busy=0, then -> IDLE. cmd_ready is low in FIN, so the minimum gap between back-to-back commands is 1 idle cycle after done.
- abort in RUN: -> FIN next cycle. No further edges; phase and position are kept. An edge scheduled in the same cycle as abort is suppressed. abort in IDLE/FIN is ignored.
- Phase and position persist across commands; only reset clears them. A new command continues the Gray sequence from the current phase, so no glitch or skipped state.
- cmd_period and cmd_steps are sampled only at accept. Changes during RUN have no effect.
- Asynchronous reset mid-run: all outputs return immediately to their reset values, with no done pulse.

Decomposition:
- Package quad_enc_pkg:
  - state enum (IDLE, RUN, FIN);
  - phase-to-(A,B) lookup constant;
  - DIR_FWD/DIR_REV constants.
- Sub-module quad_tick_div: loadable down-counter of width DIV_W.
  - Inputs: load, load_val, en.
  - Output: one-cycle tick at terminal count, auto-reloading.
  - Shared later with a PWM test generator.

Test Plan:
- Forward: accept steps=+4, period=3 at cycle T. (A,B) sequence 10@T+3, 11@T+6, 01@T+9, 00@T+12. position=4, done pulse at T+13, busy low after.
- Reverse: from reset, steps=-2, period=1. (A,B) goes 01 then 11. position=-2 (0xFFFE). done fires once.
- Zero/degenerate: steps=0 -> no edge, done pulse one cycle after accept. Then steps=+1, period=0 -> edge exactly 1 cycle after accept (period treated as 1).
- Wrap: preload position near max by running steps=+32767, then steps=+2. position goes 0x7FFF -> 0x8000 -> 0x8001 with no stall. cmd_valid held during RUN is not accepted until IDLE.
- Abort/reset: steps=+10, period=5. Assert abort coincident with the 3rd tick -> only 2 edges, (A,B)=11, done pulse. Separately, assert reset mid-run -> enc_a/enc_b/position/busy all 0 asynchronously.
- Back-to-back continuity: +3 then -3 commands. The Gray sequence is continuous (single-bit changes only), and position returns to 0 with final (A,B)=00.
